// File: rtl/alu_issue.sv
// Decode/issue stage for the integer ALU: decodes OP, OP-IMM, LUI and AUIPC, gathers
// operands and holds one issue bundle behind a valid/ready handshake.
module alu_issue #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [31:0]      i_in_instr,
  input  logic [WIDTH-1:0] i_in_pc,
  output logic [4:0]       o_rf_raddr1,
  output logic [4:0]       o_rf_raddr2,
  input  logic [WIDTH-1:0] i_rf_rdata1,
  input  logic [WIDTH-1:0] i_rf_rdata2,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [3:0]       o_out_op,
  output logic [WIDTH-1:0] o_out_rs1,
  output logic [WIDTH-1:0] o_out_rs2,
  output logic [4:0]       o_out_rd,
  output logic             o_out_illegal
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic             w_accept;
  logic [6:0]       w_opcode, w_funct7;
  logic [2:0]       w_funct3;
  logic [3:0]       w_op, w_base_op;
  logic [WIDTH-1:0] w_rs1, w_rs2, w_imm_i, w_imm_u;
  logic             w_illegal;

  assign w_opcode = i_in_instr[6:0];
  assign w_funct3 = i_in_instr[14:12];
  assign w_funct7 = i_in_instr[31:25];
  assign w_imm_i  = {{(WIDTH-12){i_in_instr[31]}}, i_in_instr[31:20]};
  assign w_imm_u  = {{(WIDTH-32){i_in_instr[31]}}, i_in_instr[31:12], 12'b0};

  assign o_rf_raddr1 = i_in_instr[19:15];
  assign o_rf_raddr2 = i_in_instr[24:20];

  // Ready is suppressed during reset so nothing is accepted in that cycle.
  assign o_in_ready  = !i_rst && ((r_state == EMPTY) || i_out_ready);
  assign w_accept    = i_in_valid && o_in_ready;
  assign o_out_valid = (r_state == FULL);

  always_comb begin
    w_base_op = ALU_ADD;
    case (w_funct3)
      3'b000:  w_base_op = ALU_ADD;
      3'b001:  w_base_op = ALU_SLL;
      3'b010:  w_base_op = ALU_SLT;
      3'b011:  w_base_op = ALU_SLTU;
      3'b100:  w_base_op = ALU_XOR;
      3'b101:  w_base_op = ALU_SRL;
      3'b110:  w_base_op = ALU_OR;
      3'b111:  w_base_op = ALU_AND;
      default: w_base_op = ALU_ADD;
    endcase
  end

  always_comb begin
    w_op      = ALU_ADD;
    w_rs1     = '0;
    w_rs2     = '0;
    w_illegal = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_rs1 = i_rf_rdata1;
        w_rs2 = i_rf_rdata2;
        if (w_funct7 == F7_BASE) begin
          w_op = w_base_op;
        end else if (w_funct7 == F7_ALT && w_funct3 == 3'b000) begin
          w_op = ALU_SUB;
        end else if (w_funct7 == F7_ALT && w_funct3 == 3'b101) begin
          w_op = ALU_SRA;
        end else begin
          w_illegal = 1'b1;
        end
      end
      OPC_OPIMM: begin
        w_rs1 = i_rf_rdata1;
        w_rs2 = w_imm_i;
        // Only the shift forms constrain funct7; other funct3 values use the full immediate.
        if (w_funct3 == 3'b001) begin
          if (w_funct7 == F7_BASE) w_op = ALU_SLL;
          else w_illegal = 1'b1;
        end else if (w_funct3 == 3'b101) begin
          if (w_funct7 == F7_BASE) w_op = ALU_SRL;
          else if (w_funct7 == F7_ALT) w_op = ALU_SRA;
          else w_illegal = 1'b1;
        end else begin
          w_op = w_base_op;
        end
      end
      OPC_LUI: begin
        w_rs2 = w_imm_u;
      end
      OPC_AUIPC: begin
        w_rs1 = i_in_pc;
        w_rs2 = w_imm_u;
      end
      default: w_illegal = 1'b1;
    endcase
    // Illegal bundles carry only rd and the flag; operands are zeroed.
    if (w_illegal) begin
      w_op  = ALU_ADD;
      w_rs1 = '0;
      w_rs2 = '0;
    end else begin
      w_op = w_op;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   w_state_nxt = w_accept ? FULL : EMPTY;
      FULL:    begin
        if (i_out_ready) w_state_nxt = i_in_valid ? FULL : EMPTY;
        else w_state_nxt = FULL;
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= EMPTY;
      o_out_op      <= ALU_ADD;
      o_out_rs1     <= '0;
      o_out_rs2     <= '0;
      o_out_rd      <= 5'd0;
      o_out_illegal <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        o_out_op      <= w_op;
        o_out_rs1     <= w_rs1;
        o_out_rs2     <= w_rs2;
        o_out_rd      <= i_in_instr[11:7];
        o_out_illegal <= w_illegal;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue: decode results, handshake and reset.
module tb_alu_issue;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_OR  = 4'd8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_pc, rf_rdata1, rf_rdata2, out_rs1, out_rs2;
  logic [4:0]  rf_raddr1, rf_raddr2, out_rd;
  logic [3:0]  out_op;
  int          n_checks = 0;
  int          n_fail = 0;

  alu_issue #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_instr(in_instr), .i_in_pc(in_pc), .o_rf_raddr1(rf_raddr1), .o_rf_raddr2(rf_raddr2),
    .i_rf_rdata1(rf_rdata1), .i_rf_rdata2(rf_rdata2), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_out_op(out_op), .o_out_rs1(out_rs1), .o_out_rs2(out_rs2),
    .o_out_rd(out_rd), .o_out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'hFFF08293;
    in_pc = 32'h0; rf_rdata1 = 32'd7; rf_rdata2 = 32'd0;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_checks++; if (out_op !== ALU_ADD) begin n_fail++; $display("FAIL reset_op got %0d want 0", out_op); end
    n_checks++; if (out_rs1 !== 32'h0 || out_rs2 !== 32'h0) begin n_fail++; $display("FAIL reset_rs got %h/%h want 0/0", out_rs1, out_rs2); end
    n_checks++; if (out_rd !== 5'd0 || out_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_rd_ill got %0d/%b want 0/0", out_rd, out_illegal); end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_addi();
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'hFFF08293; rf_rdata1 = 32'd7;
    #1;
    n_checks++; if (rf_raddr1 !== 5'd1 || rf_raddr2 !== 5'd31) begin n_fail++; $display("FAIL addi_raddr got %0d/%0d want 1/31", rf_raddr1, rf_raddr2); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL addi_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b1 || out_op !== ALU_ADD) begin n_fail++; $display("FAIL addi_valid_op got %b/%0d want 1/0", out_valid, out_op); end
    n_checks++; if (out_rs1 !== 32'd7 || out_rs2 !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL addi_rs got %h/%h want 7/ffffffff", out_rs1, out_rs2); end
    n_checks++; if (out_rd !== 5'd5 || out_illegal !== 1'b0) begin n_fail++; $display("FAIL addi_rd_ill got %0d/%b want 5/0", out_rd, out_illegal); end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'h402081B3; rf_rdata1 = 32'd10; rf_rdata2 = 32'd3;
    @(posedge clk); #1;
    n_checks++; if (out_op !== ALU_SUB || out_rs1 !== 32'd10 || out_rs2 !== 32'd3 || out_rd !== 5'd3) begin
      n_fail++; $display("FAIL b2b_sub got op %0d rs %h/%h rd %0d want 1 a/3 3", out_op, out_rs1, out_rs2, out_rd); end
    @(negedge clk);
    in_instr = 32'h4030D213; rf_rdata1 = 32'd20; rf_rdata2 = 32'hDEAD;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b1 || out_op !== ALU_SRA || out_rs1 !== 32'd20 || out_rs2 !== 32'h403 || out_rd !== 5'd4) begin
      n_fail++; $display("FAIL b2b_sra got v %b op %0d rs %h/%h rd %0d want 1 7 14/403 4", out_valid, out_op, out_rs1, out_rs2, out_rd); end
    @(negedge clk);
    in_instr = 32'h0020E333; rf_rdata1 = 32'hF0; rf_rdata2 = 32'h0F;
    @(posedge clk); #1;
    n_checks++; if (out_op !== ALU_OR || out_rs1 !== 32'hF0 || out_rs2 !== 32'h0F || out_rd !== 5'd6) begin
      n_fail++; $display("FAIL b2b_or got op %0d rs %h/%h rd %0d want 8 f0/0f 6", out_op, out_rs1, out_rs2, out_rd); end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'hFFF08293; rf_rdata1 = 32'd7;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0; in_instr = 32'h12345097; in_pc = 32'h100; rf_rdata1 = 32'd99;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready cyc %0d got %b want 0", i, in_ready); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1 || out_op !== ALU_ADD || out_rs1 !== 32'd7 || out_rs2 !== 32'hFFFFFFFF || out_rd !== 5'd5) begin
        n_fail++; $display("FAIL stall_hold cyc %0d got v %b op %0d rs %h/%h rd %0d want 1 0 7/ffffffff 5", i, out_valid, out_op, out_rs1, out_rs2, out_rd); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release got %b want 1", in_ready); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b1 || out_op !== ALU_ADD || out_rs1 !== 32'h100 || out_rs2 !== 32'h12345000 || out_rd !== 5'd1 || out_illegal !== 1'b0) begin
      n_fail++; $display("FAIL auipc got v %b op %0d rs %h/%h rd %0d ill %b want 1 0 100/12345000 1 0", out_valid, out_op, out_rs1, out_rs2, out_rd, out_illegal); end
    @(negedge clk);
    in_instr = 32'hABCDE3B7; rf_rdata1 = 32'h55;
    @(posedge clk); #1;
    n_checks++; if (out_op !== ALU_ADD || out_rs1 !== 32'h0 || out_rs2 !== 32'hABCDE000 || out_rd !== 5'd7) begin
      n_fail++; $display("FAIL lui got op %0d rs %h/%h rd %0d want 0 0/abcde000 7", out_op, out_rs1, out_rs2, out_rd); end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    logic [31:0] vec [3];
    logic [4:0]  rd_exp [3];
    vec[0] = 32'h02208033; rd_exp[0] = 5'd0;
    vec[1] = 32'h0000000F; rd_exp[1] = 5'd0;
    vec[2] = 32'h40109093; rd_exp[2] = 5'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1; in_instr = vec[i]; rf_rdata1 = 32'h1234; rf_rdata2 = 32'h5678;
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_op !== ALU_ADD || out_rs1 !== 32'h0 || out_rs2 !== 32'h0 || out_rd !== rd_exp[i]) begin
        n_fail++; $display("FAIL illegal_%0d got v %b ill %b op %0d rs %h/%h rd %0d want 1 1 0 0/0 %0d", i, out_valid, out_illegal, out_op, out_rs1, out_rs2, out_rd, rd_exp[i]); end
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'hFFF08293; rf_rdata1 = 32'd7;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0; rst = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_ready got %b want 0", in_ready); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0 || out_op !== ALU_ADD || out_rs1 !== 32'h0 || out_rs2 !== 32'h0 || out_rd !== 5'd0 || out_illegal !== 1'b0) begin
      n_fail++; $display("FAIL rstmid got v %b op %0d rs %h/%h rd %0d ill %b want all 0", out_valid, out_op, out_rs1, out_rs2, out_rd, out_illegal); end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_after got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
